// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// Opcodes, funct codes, ALU/PC/memory selects and decoder bundle.
package mips_ctrl_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_ERR
   } state_e;

   typedef enum logic [2:0] {
      CLS_R, CLS_IMM, CLS_BR, CLS_J, CLS_JR, CLS_LOAD, CLS_STORE
   } cls_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // Immediate ops reuse the R-type funct of the matching ALU operation.
   localparam logic [5:0] ALU_OP_ADD  = 6'h20;
   localparam logic [5:0] ALU_OP_ADDU = 6'h21;
   localparam logic [5:0] ALU_OP_AND  = 6'h24;
   localparam logic [5:0] ALU_OP_OR   = 6'h25;
   localparam logic [5:0] ALU_OP_SLT  = 6'h2A;
   localparam logic [5:0] ALU_OP_BEQ  = 6'h30;
   localparam logic [5:0] ALU_OP_BNE  = 6'h31;
   localparam logic [5:0] ALU_OP_LUI  = 6'h32;

   localparam logic [1:0] PC_SRC_PC4    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_JR     = 2'd3;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   typedef struct packed {
      cls_e       cls;
      logic [5:0] alu_op;
      logic [1:0] mem_size;
      logic       legal;
   } dec_t;

endpackage

// File: rtl/mips_ctrl_if.sv
// Sequencer <-> datapath bundle: instruction/status in, controls out.
interface mips_ctrl_if;
   logic [31:0] ins;
   logic        alu_branch;
   logic        mem_ready;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        reg_dst;
   logic        reg_write;
   logic        alu_src;
   logic [5:0]  alu_op;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_to_reg;
   logic        illegal;

   modport master (
      input  ins, alu_branch, mem_ready,
      output pc_write, pc_src, reg_dst, reg_write, alu_src, alu_op,
      output mem_read, mem_write, mem_size, mem_to_reg, illegal
   );

   modport slave (
      output ins, alu_branch, mem_ready,
      input  pc_write, pc_src, reg_dst, reg_write, alu_src, alu_op,
      input  mem_read, mem_write, mem_size, mem_to_reg, illegal
   );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Opcode/funct classifier: instruction class, ALU code, access size, legal.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec
);
   always_comb begin
      dec          = '0;
      dec.cls      = CLS_IMM;
      dec.mem_size = MEM_SIZE_BYTE;
      unique case (op)
         OP_RTYPE: begin
            dec.cls = CLS_R;
            unique case (funct)
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR,
               F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: begin
                  dec.legal  = 1'b1;
                  dec.alu_op = funct;
               end
               F_JR: begin
                  dec.legal  = 1'b1;
                  dec.alu_op = funct;
                  dec.cls    = CLS_JR;
               end
               default: ;
            endcase
         end
         OP_J: begin
            dec.legal = 1'b1;
            dec.cls   = CLS_J;
         end
         OP_BEQ, OP_BNE: begin
            dec.legal  = 1'b1;
            dec.cls    = CLS_BR;
            dec.alu_op = (op == OP_BEQ) ? ALU_OP_BEQ : ALU_OP_BNE;
         end
         OP_ADDI:  begin dec.legal = 1'b1; dec.alu_op = ALU_OP_ADD;  end
         OP_ADDIU: begin dec.legal = 1'b1; dec.alu_op = ALU_OP_ADDU; end
         OP_SLTI:  begin dec.legal = 1'b1; dec.alu_op = ALU_OP_SLT;  end
         OP_ANDI:  begin dec.legal = 1'b1; dec.alu_op = ALU_OP_AND;  end
         OP_ORI:   begin dec.legal = 1'b1; dec.alu_op = ALU_OP_OR;   end
         OP_LUI:   begin dec.legal = 1'b1; dec.alu_op = ALU_OP_LUI;  end
         OP_LB, OP_LBU, OP_LW: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_LOAD;
            dec.alu_op   = ALU_OP_ADD;
            dec.mem_size = (op == OP_LW) ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
         end
         OP_SB, OP_SW: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_STORE;
            dec.alu_op   = ALU_OP_ADD;
            dec.mem_size = (op == OP_SW) ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Define MIPS_CTRL_STALL_EN to hold MEM until mem_ready.
module mips_ctrl_fsm
   import mips_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   mips_ctrl_if.master bus
);
   localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
   localparam logic [2:0] S_DECODE = 3'(ST_DECODE);
   localparam logic [2:0] S_EXEC   = 3'(ST_EXEC);
   localparam logic [2:0] S_MEM    = 3'(ST_MEM);
   localparam logic [2:0] S_WB     = 3'(ST_WB);
   localparam logic [2:0] S_ERR    = 3'(ST_ERR);

   logic [2:0]  state, state_nxt;
   logic [31:0] ir;
   dec_t        dec;
   logic        mem_done;
   logic        unused_ir;

   assign unused_ir = ^ir[25:6];

`ifdef MIPS_CTRL_STALL_EN
   assign mem_done = bus.mem_ready;
`else
   logic unused_ready;
   assign unused_ready = bus.mem_ready;
   assign mem_done     = 1'b1;
`endif

   mips_ctrl_decode u_dec (
      .op    (ir[31:26]),
      .funct (ir[5:0]),
      .dec   (dec)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH) ir <= bus.ins;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = dec.legal ? S_EXEC : S_ERR;
         S_EXEC: begin
            unique case (dec.cls)
               CLS_BR, CLS_J, CLS_JR: state_nxt = S_FETCH;
               CLS_LOAD, CLS_STORE:   state_nxt = S_MEM;
               default:               state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_done)
               state_nxt = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
         end
         S_WB:    state_nxt = S_FETCH;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_FETCH;
      endcase
   end

   logic       pc_write, reg_dst, reg_write, alu_src;
   logic       mem_read, mem_write, mem_to_reg;
   logic [1:0] pc_src, mem_size;
   logic [5:0] alu_op;

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_PC4;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_size   = MEM_SIZE_BYTE;
      mem_to_reg = 1'b1;
      unique case (state)
         S_DECODE: alu_op = dec.alu_op;
         S_EXEC: begin
            alu_op  = dec.alu_op;
            alu_src = (dec.cls == CLS_IMM) || (dec.cls == CLS_LOAD) ||
                      (dec.cls == CLS_STORE);
            unique case (dec.cls)
               CLS_BR: begin
                  pc_write = 1'b1;
                  pc_src   = bus.alu_branch ? PC_SRC_BRANCH : PC_SRC_PC4;
               end
               CLS_J:  begin pc_write = 1'b1; pc_src = PC_SRC_JUMP; end
               CLS_JR: begin pc_write = 1'b1; pc_src = PC_SRC_JR;   end
               default: ;
            endcase
         end
         S_MEM: begin
            alu_op    = dec.alu_op;
            mem_read  = (dec.cls == CLS_LOAD);
            mem_write = (dec.cls == CLS_STORE);
            mem_size  = dec.mem_size;
            // A stalled store retires only on the edge that leaves MEM.
            pc_write  = (dec.cls == CLS_STORE) && mem_done;
         end
         S_WB: begin
            alu_op     = dec.alu_op;
            reg_write  = 1'b1;
            reg_dst    = (dec.cls == CLS_R);
            mem_to_reg = (dec.cls != CLS_LOAD);
            pc_write   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.pc_write   = pc_write;
   assign bus.pc_src     = pc_src;
   assign bus.reg_dst    = reg_dst;
   assign bus.reg_write  = reg_write;
   assign bus.alu_src    = alu_src;
   assign bus.alu_op     = alu_op;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.mem_size   = mem_size;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.illegal    = (state == S_ERR);
endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Scoreboard bench for mips_ctrl_fsm: per-cycle expected controls queued
// by the driver, popped and compared by an independent monitor.
module tb_mips_ctrl_fsm;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src;
      logic [5:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_size;
      logic       mem_to_reg;
      logic       illegal;
   } ctl_t;

`ifdef MIPS_CTRL_STALL_EN
   localparam logic RDY_IDLE = 1'b1;
`else
   localparam logic RDY_IDLE = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic probe = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   ctl_t  exp_q[$];
   string nm_q[$];

   mips_ctrl_if bus ();

   mips_ctrl_fsm dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic ctl_t idle();
      ctl_t c;
      c = '0;
      c.mem_to_reg = 1'b1;
      return c;
   endfunction

   function automatic ctl_t alu(input logic [5:0] a);
      ctl_t c;
      c = idle();
      c.alu_op = a;
      return c;
   endfunction

   // Monitor: independent of the driver, compares whatever is queued.
   always @(negedge clock or posedge probe) begin
      ctl_t  e, g;
      string nm;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         nm = nm_q.pop_front();
         g = '{bus.pc_write, bus.pc_src, bus.reg_dst, bus.reg_write,
               bus.alu_src, bus.alu_op, bus.mem_read, bus.mem_write,
               bus.mem_size, bus.mem_to_reg, bus.illegal};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h", nm, g, e);
         end
      end
   end

   task automatic push(input ctl_t e, input string nm);
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic drive(input logic [31:0] i, input ctl_t e,
                        input string nm);
      bus.ins = i;
      push(e, nm);
      @(posedge clock);
      #1;
   endtask

   task automatic run_alu(input string nm, input logic [31:0] i,
                          input logic [5:0] a, input logic rtype);
      ctl_t e;
      drive(i, idle(), {nm, "_f"});
      drive(i, alu(a), {nm, "_d"});
      e = alu(a); e.alu_src = ~rtype;
      drive(i, e, {nm, "_e"});
      e = alu(a); e.reg_write = 1'b1; e.reg_dst = rtype; e.pc_write = 1'b1;
      drive(i, e, {nm, "_wb"});
   endtask

   task automatic run_br(input string nm, input logic [31:0] i,
                         input logic [5:0] a, input logic br,
                         input logic [1:0] src);
      ctl_t e;
      bus.alu_branch = br;
      drive(i, idle(), {nm, "_f"});
      drive(i, alu(a), {nm, "_d"});
      e = alu(a); e.pc_write = 1'b1; e.pc_src = src;
      drive(i, e, {nm, "_e"});
      bus.alu_branch = 1'b0;
   endtask

   task automatic run_ld(input string nm, input logic [31:0] i,
                         input logic [1:0] sz);
      ctl_t e;
      drive(i, idle(), {nm, "_f"});
      drive(i, alu(6'h20), {nm, "_d"});
      e = alu(6'h20); e.alu_src = 1'b1;
      drive(i, e, {nm, "_e"});
      e = alu(6'h20); e.mem_read = 1'b1; e.mem_size = sz;
      drive(i, e, {nm, "_mem"});
      e = alu(6'h20); e.reg_write = 1'b1; e.mem_to_reg = 1'b0;
      e.pc_write = 1'b1;
      drive(i, e, {nm, "_wb"});
   endtask

   task automatic run_st(input string nm, input logic [31:0] i,
                         input logic [1:0] sz, input int nwait);
      ctl_t e;
      drive(i, idle(), {nm, "_f"});
      drive(i, alu(6'h20), {nm, "_d"});
      e = alu(6'h20); e.alu_src = 1'b1;
      drive(i, e, {nm, "_e"});
      e = alu(6'h20); e.mem_write = 1'b1; e.mem_size = sz;
      for (int k = 0; k < nwait; k++) begin
         bus.mem_ready = 1'b0;
         drive(i, e, {nm, "_wait"});
      end
      bus.mem_ready = RDY_IDLE;
      e.pc_write = 1'b1;
      drive(i, e, {nm, "_mem"});
   endtask

   task automatic run_err(input string nm, input logic [31:0] i,
                          input int ncyc);
      ctl_t e;
      drive(i, idle(), {nm, "_f"});
      drive(i, idle(), {nm, "_d"});
      e = idle(); e.illegal = 1'b1;
      for (int k = 0; k < ncyc; k++) drive(i, e, {nm, "_err"});
      reset = 1'b0;
      drive(32'h0, idle(), {nm, "_rst"});
      reset = 1'b1;
   endtask

   initial begin
      ctl_t e;
      bus.ins        = 32'h0;
      bus.alu_branch = 1'b0;
      bus.mem_ready  = RDY_IDLE;
      @(posedge clock);
      #1;
      drive(32'h0, idle(), "reset0");
      drive(32'h0, idle(), "reset1");
      reset = 1'b1;

      run_alu("add", 32'h0022_1820, 6'h20, 1'b1);
      run_ld("lw", 32'h8C85_0008, 2'd2);
      run_br("beq_t", 32'h1022_0004, 6'h30, 1'b1, 2'd1);
      run_br("beq_n", 32'h1022_0004, 6'h30, 1'b0, 2'd0);
      run_br("bne_t", 32'h1422_0004, 6'h31, 1'b1, 2'd1);
      run_br("j", 32'h0800_0010, 6'h00, 1'b0, 2'd2);
      run_br("jr", 32'h03E0_0008, 6'h08, 1'b0, 2'd3);
      run_alu("ori", 32'h3422_0055, 6'h25, 1'b0);
      run_alu("lui", 32'h3C01_1234, 6'h32, 1'b0);
      run_alu("sub", 32'h0022_1822, 6'h22, 1'b1);
      run_ld("lbu", 32'h9085_0001, 2'd0);
      run_st("sw", 32'hAC85_0008, 2'd2, 0);
`ifdef MIPS_CTRL_STALL_EN
      run_st("sb_stall", 32'hA085_0003, 2'd0, 3);
`else
      run_st("sb", 32'hA085_0003, 2'd0, 0);
`endif
      run_err("op3f", 32'hFC00_0000, 20);
      run_alu("add_r", 32'h0022_1820, 6'h20, 1'b1);
      run_err("fn01", 32'h0000_0001, 3);

      // Reset pulse in the middle of a store's MEM cycle.
      drive(32'hAC85_0008, idle(), "swr_f");
      drive(32'hAC85_0008, alu(6'h20), "swr_d");
      e = alu(6'h20); e.alu_src = 1'b1;
      drive(32'hAC85_0008, e, "swr_e");
      #1;
      e = alu(6'h20); e.mem_write = 1'b1; e.mem_size = 2'd2; e.pc_write = 1'b1;
      push(e, "swr_mem");
      probe = 1'b1;
      #1;
      probe = 1'b0;
      reset = 1'b0;
      #1;
      push(idle(), "swr_async");
      probe = 1'b1;
      #1;
      probe = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      run_alu("add_after", 32'h0022_1820, 6'h20, 1'b1);

      @(negedge clock);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle control sequencer for the MIPS datapath in `processor`. It latches each fetched instruction and steps it through the FETCH → DECODE → EXEC → MEM → WB phases. Each phase drives the mux selects, the register-file and data-memory enables, and the PC update. The block replaces the loose per-signal control wires (RegDst, RegWrite, ALUSrc, ALUop, MemToReg, RE/WE, size) with one sequenced controller.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value that `pc_next` presents while the block is in reset.
- `clock` input 1: sole clock; rising edge.
- `reset` input 1: asynchronous, active-low.
- `ins` input 32: instruction-ROM output; sampled at the end of FETCH.
- `alu_branch` input 1: ALU compare result (branch condition true).
- `mem_ready` input 1: data-memory/serial access complete; used only when `MIPS_CTRL_STALL_EN` is defined.
- `pc_write` output 1: load PC with `pc_src`-selected value this cycle.
- `pc_src` output 2: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `reg_write` output 1: register-file write enable.
- `alu_src` output 1: 0 = rt data, 1 = sign-extended immediate.
- `alu_op` output 6: ALU function code.
- `mem_read`, `mem_write` output 1 each: data-memory RE/WE.
- `mem_size` output 2: 0 = byte, 2 = word.
- `mem_to_reg` output 1: 0 = memory data, 1 = ALU result (matches existing mux polarity).
- `illegal` output 1: sticky illegal-opcode flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, ERR.
- FETCH: load `ins` into the internal IR at the clock edge, then go to DECODE.
- DECODE: classify the opcode.
  - Legal → EXEC.
  - Unknown opcode or unknown funct → ERR, `illegal`=1.
- Supported opcodes: R-type 0x00 (funct add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr), j 0x02, beq 0x04, bne 0x05, addi 0x08, addiu 0x09, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, lb 0x20, lw 0x23, lbu 0x24, sb 0x28, sw 0x2B.
- `alu_op` source:
  - R-type: IR funct.
  - Immediate ops: the package-mapped funct equivalent.
  - beq/bne: `ALU_OP_BEQ`/`ALU_OP_BNE`.
  - Loads/stores: add (0x20).
- EXEC:
  - `alu_src`=1 for immediate, load and store ops.
  - beq/bne: `pc_write`=1; `pc_src`=1 if `alu_branch` else 0; next state FETCH.
  - j: `pc_write`=1, `pc_src`=2 → FETCH.
  - jr: `pc_write`=1, `pc_src`=3 → FETCH.
  - Loads/stores → MEM. All other ops → WB.
- MEM:
  - Loads: `mem_read`=1. Stores: `mem_write`=1.
  - `mem_size`=0 for lb/lbu/sb, 2 for lw/sw.
  - Loads → WB.
  - Stores: `pc_write`=1, `pc_src`=0 → FETCH.
- WB:
  - `reg_write`=1; `reg_dst`=1 for R-type only.
  - `mem_to_reg`=0 for loads, 1 otherwise.
  - `pc_write`=1, `pc_src`=0 → FETCH.
- ERR: all enables 0. Stays in ERR until reset.
- Outputs are a Moore decode of state and IR. Enables are 0 in every state not listed above.

## Timing
- Instruction latency in cycles:
  - branch, jump, jr: 3
  - R-type/immediate: 4
  - store: 4
  - load: 5
- `pc_write` is asserted for exactly one cycle per retired instruction, in its final state.
- Reset (asynchronous assert, any state including mid-MEM):
  - State → FETCH, IR → 0.
  - All enables, `pc_src`, `alu_op`, `mem_size` and `illegal` → 0.
  - `reg_dst`, `alu_src` → 0; `mem_to_reg` → 1.
- After reset deassertion, the first FETCH samples `ins` on the next rising edge.
- A write enable is never asserted in the same cycle as a reset release.

## Configuration
- `MIPS_CTRL_STALL_EN` defined:
  - MEM holds, with `mem_read`/`mem_write` held steady, until `mem_ready`=1.
  - The exit transition occurs on the edge where `mem_ready`=1. If `mem_ready`=1 on the first MEM cycle, MEM lasts one cycle.
- `MIPS_CTRL_STALL_EN` undefined: `mem_ready` is ignored and MEM always lasts exactly one cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - State enum.
  - Opcode and funct constants.
  - `ALU_OP_*` codes, including `ALU_OP_BEQ`, `ALU_OP_BNE`, `ALU_OP_LUI`.
  - `PC_SRC_*` and `MEM_SIZE_*` encodings.
- One sub-module, `mips_ctrl_decode`: combinational map from opcode/funct to instruction class, `alu_op`, `mem_size` and the legal flag. The FSM instantiates it on the IR.

## Test plan
- add $3,$1,$2 (0x00221820) after reset: states F,D,E,WB; `reg_write`=1, `reg_dst`=1, `mem_to_reg`=1 and `pc_write`=1 in cycle 4 only; `alu_op`=0x20.
- lw $5,8($4) (0x8C850008): 5 cycles; `mem_read`=1 and `mem_size`=2 in cycle 4; `mem_to_reg`=0 and `reg_write`=1 in cycle 5.
- beq with `alu_branch`=1, then again with `alu_branch`=0: 3 cycles each; `pc_src`=1, then 0, with `pc_write`=1 in cycle 3.
- sb with `MIPS_CTRL_STALL_EN`, `mem_ready` low for 3 cycles: `mem_write` held 4 cycles, `mem_size`=0, then `pc_write`=1 and return to FETCH.
- Opcode 0x3F: ERR after DECODE; `illegal`=1 and all enables stay 0 for 20 cycles; `reset`=0 clears `illegal` and returns to FETCH.
- `reset` pulsed low during MEM of sw: `mem_write` drops asynchronously and no `pc_write` occurs; the next instruction restarts at FETCH.
